// File: rtl/uart_tx_serial.sv
// UART transmit serializer: start, 8 data bits LSB first, optional parity, 1-2 stop bits, frames back-to-back.
// Latency: the line goes low one cycle after the handshake; o_tx_ready drops while the one-entry buffer holds a byte.
module uart_tx_serial #(
  parameter int Clock_rate = 100000000,
  parameter int Baud_rate  = 9600,
  parameter int Parity_en  = 0,
  parameter int Parity_odd = 0,
  parameter int Stop_bits  = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_TX_serial,
  output logic       o_TX_active,
  output logic       o_TX_done
);

  localparam int CLKS_PER_BIT = Clock_rate / Baud_rate;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = (Stop_bits == 2);
  localparam logic PAR_EN    = (Parity_en != 0);
  localparam logic PAR_ODD   = (Parity_odd != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [7:0]       buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic             rdy_q, rdy_d;
  logic             serial_q, serial_d;

  logic bit_end;
  logic last_stop;
  logic accept;
  logic load;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;

    bit_end   = (cnt_q == CNT_MAX);
    last_stop = (state_q == STOP) && bit_end && (stop_idx_q == STOP_LAST);
    accept    = i_tx_valid && rdy_q;
    load      = buf_full_q && ((state_q == IDLE) || last_stop);

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d    = PAR_EN ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_idx_q == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Loading from the buffer overrides the IDLE fallback at the end of STOP, giving gapless frames.
    if (load) begin
      state_d = START;
      cnt_d   = '0;
      shift_d = buf_q;
      par_d   = (^buf_q) ^ PAR_ODD;
    end

    // A same-cycle load and accept leaves the buffer full with the new byte.
    if (accept) begin
      buf_d      = i_tx_data;
      buf_full_d = 1'b1;
    end else if (load) begin
      buf_full_d = 1'b0;
    end

    rdy_d = !buf_full_d;

    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      PARITY:  serial_d = par_d;
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      buf_q      <= 8'h00;
      buf_full_q <= 1'b0;
      rdy_q      <= 1'b1;
      serial_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      rdy_q      <= rdy_d;
      serial_q   <= serial_d;
    end
  end

  assign o_tx_ready  = rdy_q;
  assign o_TX_serial = serial_q;
  assign o_TX_active = (state_q != IDLE);
  assign o_TX_done   = last_stop;

endmodule

// File: doc/uart_tx_serial.md
Name: uart_tx_serial

Overview:
- UART transmit serializer: accepts parallel bytes over a valid/ready handshake and drives a standard asynchronous serial line.
- Frame format: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Contains an internal baud counter and a one-entry holding buffer, so the next byte is accepted while the current frame is shifting out.
- Frames are sent back-to-back with no idle gap.
- Pairs with the receive path as the outbound end of the serial link.

Parameters:
- Clock_rate, 100000000, input clock frequency in Hz.
- Baud_rate, 9600, line rate in bit/s. CLKS_PER_BIT = Clock_rate/Baud_rate, truncated (10416 at defaults); must be >= 2.
- Parity_en, 0, 1 inserts a parity bit after data bit 7.
- Parity_odd, 0, 0 = even parity, 1 = odd parity. Ignored when Parity_en = 0.
- Stop_bits, 1, number of stop bits; legal values 1 or 2.

Ports:
- i_Clk  input  1  system clock, rising-edge.
- i_Rst_n  input  1  reset, asynchronous assert, active-low.
- i_tx_data  input  8  byte to send; sampled on handshake.
- i_tx_valid  input  1  producer has a byte; must hold it, with i_tx_data stable, until accepted.
- o_tx_ready  output  1  holding buffer empty; a byte can be accepted.
- o_TX_serial  output  1  serial line; idles high.
- o_TX_active  output  1  high while a frame is on the line (START through STOP).
- o_TX_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset (i_Rst_n = 0, asynchronous):
  - FSM goes to IDLE; holding buffer empty; baud counter and bit index cleared.
  - Outputs: o_TX_serial = 1, o_tx_ready = 1, o_TX_active = 0, o_TX_done = 0.
  - Reset asserted mid-frame aborts the frame; the line returns high immediately; buffered data is discarded.
- Handshake:
  - A byte is accepted on any rising edge where i_tx_valid and o_tx_ready are both high; the buffer becomes full.
  - o_tx_ready = !buf_full, registered. It is 0 in the cycle after acceptance.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE with buffer full: the next edge loads the shift register from the buffer, empties the buffer and enters START.
  - Latency: handshake at edge N, buffer load at edge N+1, o_TX_serial = 0 from edge N+1.
- Each bit state lasts exactly CLKS_PER_BIT cycles, counted from 0 to CLKS_PER_BIT-1.
- Sequence:
  - START drives 0.
  - DATA drives shift[0] for bits 0..7, shifting right after each bit.
  - PARITY (only if Parity_en) drives ^data XOR Parity_odd, computed on the loaded byte.
  - STOP drives 1 for Stop_bits bit periods.
- End of STOP:
  - On the final stop cycle, o_TX_done = 1.
  - At that edge, if the buffer is full, load it and go directly to START (no idle cycle); otherwise go to IDLE.
- Frame length is exactly (1+8+Parity_en+Stop_bits)*CLKS_PER_BIT cycles.
- Simultaneous buffer load by the FSM and a new handshake in the same cycle: the FSM takes the old byte and the buffer takes the new byte, ending full. No loss, no duplication.
- o_TX_active = 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Valid deasserted while ready is low: no effect. Data changed without a handshake: ignored.
- o_TX_serial comes directly from a register (glitch-free).

Test Plan:
Bench uses Clock_rate=1000000, Baud_rate=100000, giving CLKS_PER_BIT=10.
- Reset, no stimulus -> o_TX_serial=1, o_tx_ready=1, o_TX_active=0 for 100 cycles.
- Send 0x55 (Parity_en=0, Stop_bits=1) -> line 0,1,0,1,0,1,0,1,0,1, each 10 cycles; o_TX_done pulses once at cycle 100 after load; o_TX_active high for exactly 100 cycles.
- Parity_en=1, even, byte 0x07 -> parity bit 1; with Parity_odd=1 -> 0; frame is 110 cycles; Stop_bits=2 gives 120 cycles.
- Back-to-back 0xA5 then 0x3C, valid held -> second accepted while first shifts; no gap between first stop bit and second start bit; 200 contiguous cycles; two o_TX_done pulses 100 cycles apart.
- Producer holds valid with 0x3C while ready=0 for 50 cycles -> exactly one acceptance, exactly one frame of 0x3C.
- Assert i_Rst_n=0 at cycle 45 of a frame -> o_TX_serial=1 asynchronously, ready=1, no o_TX_done pulse; a fresh 0x81 afterwards transmits correctly.
